// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 VGA timing constants and the raster phase type
// Contents: default porch/sync/active lengths, H_TOTAL/V_TOTAL for those defaults,
// phase_t shared by the horizontal and vertical phase FSMs.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter plus ACTIVE/FRONT/SYNC/BACK phase FSM for one raster axis
// Ports: clk, rst_n (sync active-low, loads last position / BACK), en (advance one step),
// cnt (current position), phase_nxt (phase after this edge), wrap (at last position and advancing).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN = DEF_H_FRONT,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BACK_LEN = DEF_H_BACK,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output phase_t       phase_nxt,
  output logic         wrap
);
  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam logic [W-1:0] A_END = W'(ACTIVE_LEN - 1);
  localparam logic [W-1:0] F_END = W'(ACTIVE_LEN + FRONT_LEN - 1);
  localparam logic [W-1:0] S_END = W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] T_END = W'(TOTAL - 1);
  if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1 || TOTAL > 2 ** W) begin : g_bad_len
    $error("vga_axis_counter: every phase needs length >= 1 and the total must fit in W bits");
  end
  phase_t phase;
  logic [W-1:0] last;
  // phase steps only when the counter sits on the last position of the current phase
  always_comb begin
    last = phase == ACTIVE ? A_END : phase == FRONT ? F_END : phase == SYNC ? S_END : T_END;
    wrap = en && cnt == T_END;
    phase_nxt = en && cnt == last ? phase_t'(phase + 2'd1) : phase;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= T_END;
      phase <= BACK;
    end else begin
      cnt <= wrap ? '0 : cnt + W'(en);
      phase <= phase_nxt;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing (default 640x480@60) from one pixel clock
// Ports: vgaclock, vgareset_n (sync active-low), vgacol/vgarow (raster position),
// vgavalid (visible pixel), vgahsync/vgavsync (level per SYNC_POL), vgaframe_start (pulse at (0,0)).
// Option: define VGA_TIMING_SYNC_DELAY_EN to delay hsync/vsync one extra cycle to line up
// with a registered colour stage downstream.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter int SYNC_POL = 0
) (
  input  logic       vgaclock,
  input  logic       vgareset_n,
  output logic [9:0] vgacol,
  output logic [9:0] vgarow,
  output logic       vgavalid,
  output logic       vgahsync,
  output logic       vgavsync,
  output logic       vgaframe_start
);
  localparam int H_LEN = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_LEN = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic ON = 1'(SYNC_POL);
  if (H_LEN > 1024 || V_LEN > 1024) begin : g_bad_size
    $error("vga_timing_gen: H and V totals must not exceed 1024");
  end
  phase_t h_phase_nxt, v_phase_nxt;
  logic h_wrap, v_wrap, hs, vs;
  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK), .W(10)
  ) u_h (
    .clk(vgaclock), .rst_n(vgareset_n), .en(1'b1),
    .cnt(vgacol), .phase_nxt(h_phase_nxt), .wrap(h_wrap)
  );
  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK), .W(10)
  ) u_v (
    .clk(vgaclock), .rst_n(vgareset_n), .en(h_wrap),
    .cnt(vgarow), .phase_nxt(v_phase_nxt), .wrap(v_wrap)
  );
  // flags are registered from next-state so they land on the same edge as the counters;
  // v_wrap is only true when h also wraps, so it marks the step into (0,0)
  always_ff @(posedge vgaclock)
    if (!vgareset_n) begin
      vgavalid <= 1'b0;
      hs <= ~ON;
      vs <= ~ON;
      vgaframe_start <= 1'b0;
    end else begin
      vgavalid <= h_phase_nxt == ACTIVE && v_phase_nxt == ACTIVE;
      hs <= h_phase_nxt == SYNC ? ON : ~ON;
      vs <= v_phase_nxt == SYNC ? ON : ~ON;
      vgaframe_start <= v_wrap;
    end
`ifdef VGA_TIMING_SYNC_DELAY_EN
  always_ff @(posedge vgaclock)
    if (!vgareset_n) begin
      vgahsync <= ~ON;
      vgavsync <= ~ON;
    end else begin
      vgahsync <= hs;
      vgavsync <= vs;
    end
`else
  assign vgahsync = hs;
  assign vgavsync = vs;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-reset bench for vga_timing_gen against a linear-position raster model
module tb_vga_timing_gen;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4, VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT_B = HA + HF + HS + HB;
  localparam int TOT_B = HT_B * (VA + VF + VS + VB);
  localparam int HT_A = 800;
  localparam int TOT_A = 800 * 525;
  logic vgaclock = 1'b0;
  logic vgareset_n = 1'b0;
  logic [9:0] col_a, row_a, col_b, row_b;
  logic valid_a, hs_a, vs_a, fs_a, valid_b, hs_b, vs_b, fs_b;
  int checks = 0;
  int failures = 0;
  int pos_a, pos_b;
  logic [1:0] dly_a, dly_b;
  logic [3:0] fl_a, fl_b;
  bit armed = 0;
  always #5 vgaclock = ~vgaclock;
  vga_timing_gen dut_a (
    .vgaclock(vgaclock), .vgareset_n(vgareset_n), .vgacol(col_a), .vgarow(row_a),
    .vgavalid(valid_a), .vgahsync(hs_a), .vgavsync(vs_a), .vgaframe_start(fs_a)
  );
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1)
  ) dut_b (
    .vgaclock(vgaclock), .vgareset_n(vgareset_n), .vgacol(col_b), .vgarow(row_b),
    .vgavalid(valid_b), .vgahsync(hs_b), .vgavsync(vs_b), .vgaframe_start(fs_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask
  // {valid, hsync, vsync, frame_start} for linear raster position pos
  function automatic logic [3:0] flags(input int pos, input int ha, input int hf, input int hs,
                                       input int hb, input int va, input int vf, input int vs,
                                       input logic on);
    int ht = ha + hf + hs + hb;
    int c = pos % ht;
    int r = pos / ht;
    return {c < ha && r < va, (c >= ha + hf && c < ha + hf + hs) ? on : ~on,
            (r >= va + vf && r < va + vf + vs) ? on : ~on, pos == 0};
  endfunction
  always_comb begin
    fl_a = flags(pos_a, 640, 16, 96, 48, 480, 10, 2, 1'b0);
    fl_b = flags(pos_b, HA, HF, HS, HB, VA, VF, VS, 1'b1);
  end
  always @(posedge vgaclock)
    if (!vgareset_n) begin
      pos_a <= TOT_A - 1;
      pos_b <= TOT_B - 1;
      dly_a <= 2'b11;
      dly_b <= 2'b00;
      armed <= 1;
    end else begin
      dly_a <= fl_a[2:1];
      dly_b <= fl_b[2:1];
      pos_a <= (pos_a + 1) % TOT_A;
      pos_b <= (pos_b + 1) % TOT_B;
    end
  always @(negedge vgaclock)
    if (armed) begin
      check("col_a", col_a, pos_a % HT_A);
      check("row_a", row_a, pos_a / HT_A);
      check("valid_a", valid_a, fl_a[3]);
      check("frame_start_a", fs_a, fl_a[0]);
      check("col_b", col_b, pos_b % HT_B);
      check("row_b", row_b, pos_b / HT_B);
      check("valid_b", valid_b, fl_b[3]);
      check("frame_start_b", fs_b, fl_b[0]);
`ifdef VGA_TIMING_SYNC_DELAY_EN
      check("hsync_a", hs_a, dly_a[1]);
      check("vsync_a", vs_a, dly_a[0]);
      check("hsync_b", hs_b, dly_b[1]);
      check("vsync_b", vs_b, dly_b[0]);
`else
      check("hsync_a", hs_a, fl_a[2]);
      check("vsync_a", vs_a, fl_a[1]);
      check("hsync_b", hs_b, fl_b[2]);
      check("vsync_b", vs_b, fl_b[1]);
`endif
    end
  initial begin
    int since, vcnt, frames;
    bit started;
    since = 0;
    vcnt = 0;
    frames = 0;
    started = 0;
    repeat (3) @(negedge vgaclock);
    vgareset_n = 1'b1;
    for (int i = 0; i < 3 * TOT_B + 1; i++) begin
      @(negedge vgaclock);
      if (fs_b) begin
        if (started) begin
          check("frame_period_b", since, TOT_B);
          check("valid_per_frame_b", vcnt, HA * VA);
          frames++;
        end
        started = 1;
        since = 1;
        vcnt = int'(valid_b);
      end else begin
        since++;
        vcnt += int'(valid_b);
      end
    end
    check("frames_seen_b", frames, 3);
    for (int i = 0; i < 3000; i++) begin
      @(negedge vgaclock);
      vgareset_n = $urandom_range(0, 149) != 0;
    end
    @(negedge vgaclock);
    vgareset_n = 1'b1;
    repeat (3) @(negedge vgaclock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
